// File: rtl/cpu_mon_pkg.sv
// Shared types and helpers for the CPU performance/trace monitor.
// Default trace record widths match a 64-bit core with 32-bit counters.
package cpu_mon_pkg;

  localparam int XLEN_DEF  = 64;
  localparam int CNT_W_DEF = 32;
  localparam int SAT_MAX_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } mon_state_t;

  typedef struct packed {
    logic [XLEN_DEF-1:0]  pc;
    logic [31:0]          insn;
    logic [CNT_W_DEF-1:0] cycle;
  } trace_rec_t;

  // Width-generic saturating increment: callers zero-extend into SAT_MAX_W bits
  // and truncate the result back to their own counter width.
  function automatic logic [SAT_MAX_W-1:0] sat_inc(
    input logic [SAT_MAX_W-1:0] val,
    input logic                 en,
    input int unsigned          width
  );
    logic [SAT_MAX_W-1:0] max_val;
    if (width >= SAT_MAX_W) begin
      max_val = '1;
    end else begin
      max_val = (SAT_MAX_W'(1) << width) - SAT_MAX_W'(1);
    end
    if (en && (val != max_val)) begin
      return val + SAT_MAX_W'(1);
    end
    return val;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous trace FIFO with a registered head record; one push and one pop
// per cycle, including push-while-full when the same cycle pops.
module trace_fifo
  import cpu_mon_pkg::*;
#(
  parameter type rec_t = trace_rec_t,
  parameter int  DEPTH = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  rec_t push_rec,
  input  logic pop,
  output logic head_valid,
  output rec_t head_rec,
  output logic full
);

  localparam int AW = $clog2(DEPTH);

  rec_t           mem [DEPTH];
  logic [AW:0]    wr_ptr_reg;
  logic [AW:0]    rd_ptr_reg;
  logic [AW:0]    wr_ptr_next;
  logic [AW:0]    rd_ptr_next;
  logic           head_valid_reg;
  rec_t           head_rec_reg;
  logic           pop_ok;
  logic           push_ok;
  logic           bypass;

  assign full = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  assign pop_ok      = pop && head_valid_reg;
  assign push_ok     = push && (!full || pop_ok);
  assign wr_ptr_next = wr_ptr_reg + (AW+1)'(push_ok);
  assign rd_ptr_next = rd_ptr_reg + (AW+1)'(pop_ok);

  // The incoming record becomes the head when it lands in the slot the read
  // pointer will point at, i.e. the FIFO is (or is about to be) empty.
  assign bypass = push_ok && (wr_ptr_reg[AW-1:0] == rd_ptr_next[AW-1:0]);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg[AW-1:0]] <= push_rec;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      head_valid_reg <= 1'b0;
      head_rec_reg   <= '0;
    end else begin
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      head_valid_reg <= (wr_ptr_next != rd_ptr_next);
      if (bypass) begin
        head_rec_reg <= push_rec;
      end else if (pop_ok) begin
        head_rec_reg <= mem[rd_ptr_next[AW-1:0]];
      end
    end
  end

  assign head_valid = head_valid_reg;
  assign head_rec   = head_rec_reg;

endmodule

// File: rtl/cpu_perf_monitor.sv
// Retire-stage performance monitor: run/drain/done sequencing, saturating
// cycle/retire/event/drop counters and a per-instruction trace FIFO.
module cpu_perf_monitor
  import cpu_mon_pkg::*;
#(
  parameter int XLEN         = 64,
  parameter int CNT_W        = 32,
  parameter int NUM_EVT      = 4,
  parameter int TRACE_DEPTH  = 16,
  parameter int DRAIN_CYCLES = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     end_program,
  input  logic                     retire_valid,
  input  logic [XLEN-1:0]          retire_pc,
  input  logic [31:0]              retire_insn,
  input  logic [NUM_EVT-1:0]       evt_in,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [XLEN-1:0]          trace_pc,
  output logic [31:0]              trace_insn,
  output logic [CNT_W-1:0]         trace_cycle,
  output logic [CNT_W-1:0]         cycle_count,
  output logic [CNT_W-1:0]         retired_count,
  output logic [NUM_EVT*CNT_W-1:0] evt_count,
  output logic [CNT_W-1:0]         drop_count,
  output logic                     busy,
  output logic                     done
);

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [31:0]      insn;
    logic [CNT_W-1:0] cycle;
  } rec_t;

  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v, input logic en);
    return CNT_W'(sat_inc(SAT_MAX_W'(v), en, CNT_W));
  endfunction

  mon_state_t       state_reg;
  logic [DW-1:0]    drain_cnt_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [CNT_W-1:0] cycle_reg;
  logic [CNT_W-1:0] retired_reg;
  logic [CNT_W-1:0] drop_reg;

  logic             active;
  logic             restart;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             drop;
  rec_t             push_rec;
  rec_t             head_rec;

  assign active  = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
  assign restart = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
  assign push    = retire_valid && active;
  assign pop     = trace_valid && trace_ready;
  assign drop    = push && fifo_full && !pop;

  assign push_rec = '{pc: retire_pc, insn: retire_insn, cycle: cycle_reg};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      drain_cnt_reg <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg <= ST_RUN;
            busy_reg  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (end_program) begin
            state_reg     <= ST_DRAIN;
            drain_cnt_reg <= '0;
          end
        end
        ST_DRAIN: begin
          drain_cnt_reg <= drain_cnt_reg + DW'(1);
          if (drain_cnt_reg == DW'(DRAIN_CYCLES - 1)) begin
            state_reg <= ST_DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        ST_DONE: begin
          if (start) begin
            state_reg <= ST_RUN;
            busy_reg  <= 1'b1;
            done_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Drops only occur on active-cycle pushes, so gating by active is exact.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_reg   <= '0;
      retired_reg <= '0;
      drop_reg    <= '0;
    end else if (restart) begin
      cycle_reg   <= '0;
      retired_reg <= '0;
      drop_reg    <= '0;
    end else if (active) begin
      cycle_reg   <= bump(cycle_reg, 1'b1);
      retired_reg <= bump(retired_reg, retire_valid);
      drop_reg    <= bump(drop_reg, drop);
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_EVT; gi++) begin : g_evt
      logic [CNT_W-1:0] cnt_reg;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          cnt_reg <= '0;
        end else if (restart) begin
          cnt_reg <= '0;
        end else if (active) begin
          cnt_reg <= bump(cnt_reg, evt_in[gi]);
        end
      end
      assign evt_count[gi*CNT_W +: CNT_W] = cnt_reg;
    end
  endgenerate

  trace_fifo #(
    .rec_t (rec_t),
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_rec   (push_rec),
    .pop        (pop),
    .head_valid (trace_valid),
    .head_rec   (head_rec),
    .full       (fifo_full)
  );

  assign trace_pc      = head_rec.pc;
  assign trace_insn    = head_rec.insn;
  assign trace_cycle   = head_rec.cycle;
  assign cycle_count   = cycle_reg;
  assign retired_count = retired_reg;
  assign drop_count    = drop_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;

endmodule

// File: tb/tb_cpu_perf_monitor.sv
// Randomised and directed bench for cpu_perf_monitor against a queue-based
// reference model; a second instance with 4-bit counters exercises saturation.
module tb_cpu_perf_monitor;

  localparam int XLEN    = 64;
  localparam int CNT_W   = 32;
  localparam int NUM_EVT = 4;
  localparam int DEPTH   = 16;
  localparam int DRAIN   = 5;
  localparam int SW      = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic               start = 1'b0;
  logic               end_program = 1'b0;
  logic               retire_valid = 1'b0;
  logic [XLEN-1:0]    retire_pc = '0;
  logic [31:0]        retire_insn = '0;
  logic [NUM_EVT-1:0] evt_in = '0;
  logic               trace_ready = 1'b0;

  logic                     trace_valid;
  logic [XLEN-1:0]          trace_pc;
  logic [31:0]              trace_insn;
  logic [CNT_W-1:0]         trace_cycle;
  logic [CNT_W-1:0]         cycle_count;
  logic [CNT_W-1:0]         retired_count;
  logic [NUM_EVT*CNT_W-1:0] evt_count;
  logic [CNT_W-1:0]         drop_count;
  logic                     busy;
  logic                     done;

  logic                  s_trace_valid;
  logic [XLEN-1:0]       s_trace_pc;
  logic [31:0]           s_trace_insn;
  logic [SW-1:0]         s_trace_cycle;
  logic [SW-1:0]         s_cycle_count;
  logic [SW-1:0]         s_retired_count;
  logic [NUM_EVT*SW-1:0] s_evt_count;
  logic [SW-1:0]         s_drop_count;
  logic                  s_busy;
  logic                  s_done;

  cpu_perf_monitor #(
    .XLEN(XLEN), .CNT_W(CNT_W), .NUM_EVT(NUM_EVT), .TRACE_DEPTH(DEPTH), .DRAIN_CYCLES(DRAIN)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .end_program(end_program),
    .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_insn(retire_insn),
    .evt_in(evt_in), .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_pc(trace_pc), .trace_insn(trace_insn), .trace_cycle(trace_cycle),
    .cycle_count(cycle_count), .retired_count(retired_count), .evt_count(evt_count),
    .drop_count(drop_count), .busy(busy), .done(done)
  );

  cpu_perf_monitor #(
    .XLEN(XLEN), .CNT_W(SW), .NUM_EVT(NUM_EVT), .TRACE_DEPTH(DEPTH), .DRAIN_CYCLES(DRAIN)
  ) dut_small (
    .clk(clk), .reset(reset), .start(start), .end_program(end_program),
    .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_insn(retire_insn),
    .evt_in(evt_in), .trace_valid(s_trace_valid), .trace_ready(trace_ready),
    .trace_pc(s_trace_pc), .trace_insn(s_trace_insn), .trace_cycle(s_trace_cycle),
    .cycle_count(s_cycle_count), .retired_count(s_retired_count), .evt_count(s_evt_count),
    .drop_count(s_drop_count), .busy(s_busy), .done(s_done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 run, 2 drain, 3 done. Counters are kept
  // unbounded and clipped to each instance's counter width when compared.
  typedef struct {
    logic [63:0] pc;
    logic [31:0] insn;
    longint      stamp;
  } mrec_t;

  mrec_t  q[$];
  int     m_phase;
  int     m_drain_seen;
  longint m_cycle, m_ret, m_drop;
  longint m_evt[NUM_EVT];

  function automatic longint clip(input longint v, input int w);
    longint lim;
    lim = (longint'(1) << w) - 1;
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_clear_counts();
    m_cycle = 0;
    m_ret   = 0;
    m_drop  = 0;
    for (int i = 0; i < NUM_EVT; i++) m_evt[i] = 0;
  endtask

  task automatic model_reset();
    m_phase      = 0;
    m_drain_seen = 0;
    model_clear_counts();
    q.delete();
  endtask

  task automatic model_edge();
    bit    in_window;
    bit    popped;
    mrec_t r;
    in_window = (m_phase == 1) || (m_phase == 2);
    popped    = (q.size() != 0) && trace_ready;
    if (popped) void'(q.pop_front());
    if (in_window && retire_valid) begin
      if (q.size() < DEPTH) begin
        r.pc = retire_pc; r.insn = retire_insn; r.stamp = m_cycle;
        q.push_back(r);
      end else begin
        m_drop++;
      end
    end
    if (in_window) begin
      m_cycle++;
      m_ret += longint'(retire_valid);
      for (int i = 0; i < NUM_EVT; i++) m_evt[i] += longint'(evt_in[i]);
    end
    case (m_phase)
      0, 3: if (start) begin model_clear_counts(); m_phase = 1; end
      1: if (end_program) begin m_phase = 2; m_drain_seen = 0; end
      default: begin
        m_drain_seen++;
        if (m_drain_seen == DRAIN) m_phase = 3;
      end
    endcase
  endtask

  task automatic check_all();
    check_val("busy", busy, (m_phase == 1) || (m_phase == 2));
    check_val("done", done, m_phase == 3);
    check_val("cycle_count", cycle_count, clip(m_cycle, CNT_W));
    check_val("retired_count", retired_count, clip(m_ret, CNT_W));
    check_val("drop_count", drop_count, clip(m_drop, CNT_W));
    for (int i = 0; i < NUM_EVT; i++)
      check_val($sformatf("evt_count[%0d]", i), evt_count[i*CNT_W +: CNT_W], clip(m_evt[i], CNT_W));
    check_val("trace_valid", trace_valid, q.size() != 0);
    if (q.size() != 0) begin
      check_val("trace_pc", trace_pc, q[0].pc);
      check_val("trace_insn", trace_insn, q[0].insn);
      check_val("trace_cycle", trace_cycle, clip(q[0].stamp, CNT_W));
      check_val("s_trace_cycle", s_trace_cycle, clip(q[0].stamp, SW));
    end
    check_val("s_trace_valid", s_trace_valid, q.size() != 0);
    check_val("s_cycle_count", s_cycle_count, clip(m_cycle, SW));
    check_val("s_retired_count", s_retired_count, clip(m_ret, SW));
    check_val("s_drop_count", s_drop_count, clip(m_drop, SW));
    check_val("s_done", s_done, m_phase == 3);
  endtask

  int n_cyc = 0;

  task automatic step(input bit st, input bit ep, input bit rv, input logic [3:0] ev, input bit rdy);
    start        = st;
    end_program  = ep;
    retire_valid = rv;
    retire_pc    = {$urandom, $urandom};
    retire_insn  = $urandom;
    evt_in       = ev;
    trace_ready  = rdy;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    n_cyc++;
    $display("cyc %0d st=%0b ep=%0b rv=%0b ev=%h rdy=%0b -> busy=%0b done=%0b cyc=%0d ret=%0d drop=%0d tv=%0b",
             n_cyc, st, ep, rv, ev, rdy, busy, done, cycle_count, retired_count, drop_count, trace_valid);
  endtask

  task automatic async_reset_pulse();
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all();
    check_val("rst_trace_pc", trace_pc, 64'd0);
    check_val("rst_trace_cycle", trace_cycle, 64'd0);
    #2 reset = 1'b1;
  endtask

  initial begin
    model_reset();
    #2;
    check_all();
    check_val("rst_trace_pc", trace_pc, 64'd0);
    check_val("rst_trace_insn", trace_insn, 64'd0);
    check_val("rst_trace_cycle", trace_cycle, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Run of 10 retiring cycles, end_program on the 10th, drain window of 5
    step(0, 0, 1, 4'hf, 1);
    step(1, 0, 0, 4'h0, 0);
    for (int i = 1; i <= 10; i++) step(0, i == 10, 1, 4'h0, 1'($urandom_range(0, 1)));
    for (int i = 0; i < DRAIN; i++) begin
      check_val("done_early", done, 1'b0);
      step(0, 1, 1, 4'h0, 1'($urandom_range(0, 1)));
    end
    check_val("done_after_drain", done, 1'b1);
    check_val("run_drain_cycles", cycle_count, 64'd15);
    check_val("run_drain_retired", retired_count, 64'd15);
    step(0, 0, 1, 4'hf, 1);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 4'h0, 1);

    // Fill to capacity, overflow by 4, then push and pop together while full
    step(1, 0, 0, 4'h0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 1, 4'h0, 0);
    check_val("full_drop4", drop_count, 64'd4);
    check_val("full_head_stamp0", trace_cycle, 64'd0);
    check_val("small_cycle_sat", s_cycle_count, 64'd15);
    step(0, 0, 1, 4'h0, 1);
    check_val("full_pushpop_drop", drop_count, 64'd4);
    check_val("full_pushpop_head", trace_cycle, 64'd1);
    for (int i = 0; i < 18; i++) step(0, 0, 0, 4'h0, 1);
    step(0, 1, 0, 4'h0, 1);
    for (int i = 0; i < DRAIN; i++) step(0, 0, 0, 4'h0, 1);

    // Event channels 1 and 3 for 7 active cycles; pulses in DONE ignored
    step(1, 0, 0, 4'hf, 1);
    for (int i = 0; i < 7; i++) step(0, 0, 1'($urandom_range(0, 1)), 4'b1010, 1);
    step(0, 1, 0, 4'h0, 1);
    for (int i = 0; i < DRAIN; i++) step(0, 0, 0, 4'h0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 4'hf, 1);
    check_val("evt_ch0", evt_count[0*CNT_W +: CNT_W], 64'd0);
    check_val("evt_ch1", evt_count[1*CNT_W +: CNT_W], 64'd7);
    check_val("evt_ch2", evt_count[2*CNT_W +: CNT_W], 64'd0);
    check_val("evt_ch3", evt_count[3*CNT_W +: CNT_W], 64'd7);

    // Randomised traffic across restarts, drains and back-pressure
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 19) == 0, $urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0,
           4'($urandom), $urandom_range(0, 2) != 0);
    end

    // Reset while draining with records queued, then a clean restart
    if (m_phase == 1 || m_phase == 2) begin
      step(0, 1, 0, 4'h0, 1);
      for (int i = 0; i < DRAIN; i++) step(0, 0, 0, 4'h0, 1);
    end
    step(1, 0, 0, 4'h0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 4'h3, 0);
    step(0, 1, 1, 4'h0, 0);
    step(0, 0, 1, 4'h0, 0);
    step(0, 0, 1, 4'h0, 0);
    check_val("mid_drain_busy", busy, 1'b1);
    check_val("mid_drain_fifo", trace_valid, 1'b1);
    async_reset_pulse();
    step(1, 0, 0, 4'h0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 4'h1, 1);
    check_val("restart_retired", retired_count, 64'd4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
